// File: rtl/mole_game_ctrl_if.sv
// Signal bundle between the mole game sequencer and its stimulus side.
// The master drives the pulses and tick, and the slave (the sequencer) returns the game status.
interface mole_game_ctrl_if;
    logic       tick_1s;
    logic       start;
    logic       hit;
    logic       miss;
    logic [2:0] state;
    logic [7:0] score;
    logic [2:0] lives;
    logic [1:0] level;
    logic [6:0] time_left;

    modport master (
        output tick_1s, start, hit, miss,
        input  state, score, lives, level, time_left
    );

    modport slave (
        input  tick_1s, start, hit, miss,
        output state, score, lives, level, time_left
    );
endinterface

// File: rtl/mole_game_ctrl.sv
// Mole game sequencer: countdown, play, level-up and end states, with score, lives, level and time.
// Every status output comes straight from a register and updates on the edge that samples the pulse.
module mole_game_ctrl #(
    parameter int READY_SEC   = 3,
    parameter int PLAY_SEC    = 60,
    parameter int LIVES_INIT  = 3,
    parameter int LEVEL_STEP  = 5,
    parameter int CLEAR_SCORE = 20,
    parameter int MAX_LEVEL   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mole_game_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READY      = 3'd1,
        ST_PLAY       = 3'd2,
        ST_GAME_OVER  = 3'd3,
        ST_LEVEL_UP   = 3'd4,
        ST_GAME_CLEAR = 3'd5
    } state_t;

    localparam logic [6:0] READY_TIME  = 7'(READY_SEC);
    localparam logic [6:0] PLAY_TIME   = 7'(PLAY_SEC);
    localparam logic [2:0] LIVES_START = 3'(LIVES_INIT);
    localparam logic [7:0] CLEAR_PTS   = 8'(CLEAR_SCORE);
    localparam logic [1:0] LEVEL_MAX   = 2'(MAX_LEVEL);

    // Kept as a plain vector so that an illegal code (6 or 7) can exist and be recovered from.
    logic [2:0] state_reg;
    logic [7:0] score_reg;
    logic [2:0] lives_reg;
    logic [1:0] level_reg;
    logic [6:0] time_reg;

    logic [7:0] score_next;
    logic [2:0] lives_next;
    logic [6:0] time_next;
    logic       level_step;

    // Saturating post-event values; PLAY decides its next state from these, not the old counts.
    always_comb begin
        score_next = score_reg;
        lives_next = lives_reg;
        time_next  = time_reg;
        level_step = 1'b0;
        if (bus.hit && score_reg != 8'hFF)
            score_next = score_reg + 8'd1;
        if (bus.miss && lives_reg != 3'd0)
            lives_next = lives_reg - 3'd1;
        if (bus.tick_1s && time_reg != 7'd0)
            time_next = time_reg - 7'd1;
        if (bus.hit && score_reg != 8'hFF && level_reg < LEVEL_MAX
            && ((32'(score_next) % LEVEL_STEP) == 0))
            level_step = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            score_reg <= 8'd0;
            lives_reg <= LIVES_START;
            level_reg <= 2'd0;
            time_reg  <= 7'd0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_GAME_OVER, ST_GAME_CLEAR: begin
                    if (bus.start) begin
                        state_reg <= ST_READY;
                        time_reg  <= READY_TIME;
                        score_reg <= 8'd0;
                        lives_reg <= LIVES_START;
                        level_reg <= 2'd0;
                    end
                end
                ST_READY: begin
                    if (bus.tick_1s) begin
                        if (time_reg == 7'd1) begin
                            state_reg <= ST_PLAY;
                            time_reg  <= PLAY_TIME;
                        end else begin
                            time_reg  <= time_next;
                        end
                    end
                end
                ST_PLAY: begin
                    score_reg <= score_next;
                    lives_reg <= lives_next;
                    time_reg  <= time_next;
                    if (score_next >= CLEAR_PTS)
                        state_reg <= ST_GAME_CLEAR;
                    else if (lives_next == 3'd0 || time_next == 7'd0)
                        state_reg <= ST_GAME_OVER;
                    else if (level_step) begin
                        state_reg <= ST_LEVEL_UP;
                        level_reg <= level_reg + 2'd1;
                    end
                end
                ST_LEVEL_UP: begin
                    if (bus.tick_1s) begin
                        time_reg  <= time_next;
                        state_reg <= (time_next == 7'd0) ? ST_GAME_OVER : ST_PLAY;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.state     = state_reg;
    assign bus.score     = score_reg;
    assign bus.lives     = lives_reg;
    assign bus.level     = level_reg;
    assign bus.time_left = time_reg;

endmodule
